// File: rtl/scan_mux_n_if.sv
// ============================================================================
// Module   : scan_mux_n_if
// Brief    : Bus bundle for scan_mux_n (channel data, select, controls, result).
//            Carries ch_mask when SCAN_MASK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface scan_mux_n_if #(
    parameter int CHANNELS = 8,
    parameter int WIDTH    = 1,
    parameter int SEL_W    = 3
);
    logic [CHANNELS*WIDTH-1:0] data_in;
    logic [SEL_W-1:0]          sel;
    logic                      mode;
    logic                      hold;
    logic [WIDTH-1:0]          data_out;
    logic [SEL_W-1:0]          ch_out;
    logic                      valid;
    logic                      scan_wrap;
`ifdef SCAN_MASK_EN
    logic [CHANNELS-1:0]       ch_mask;

    modport master (output data_in, sel, mode, hold, ch_mask,
                    input  data_out, ch_out, valid, scan_wrap);
    modport slave  (input  data_in, sel, mode, hold, ch_mask,
                    output data_out, ch_out, valid, scan_wrap);
`else
    modport master (output data_in, sel, mode, hold,
                    input  data_out, ch_out, valid, scan_wrap);
    modport slave  (input  data_in, sel, mode, hold,
                    output data_out, ch_out, valid, scan_wrap);
`endif
endinterface

`default_nettype wire

// File: rtl/scan_mux_n.sv
// ============================================================================
// Module   : scan_mux_n
// Brief    : Registered N-channel mux with manual select and round-robin
//            auto-scan. Optional macro SCAN_MASK_EN adds a per-channel mask.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_mux_n #(
    parameter int CHANNELS = 8,
    parameter int WIDTH    = 1,
    parameter int SEL_W    = 3,
    parameter int DWELL    = 4
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    scan_mux_n_if.slave bus
);

    typedef enum logic [0:0] {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } state_t;

    localparam logic [7:0] c_DWELL_LAST = 8'(DWELL - 1);

    state_t            r_state, w_nextState;
    logic [7:0]        r_cnt, w_nextCnt;
    logic [SEL_W-1:0]  r_chOut, w_nextCh, w_tgtCh, w_aboveCh, w_lowCh;
    logic [WIDTH-1:0]  r_data, w_nextData, w_tgtData;
    logic              r_valid, w_nextValid;
    logic              r_wrap, w_nextWrap;
    logic              w_tgtLegal, w_aboveFound, w_anyEnabled;
    logic [CHANNELS-1:0] w_mask;
    logic [WIDTH-1:0]  w_chan [CHANNELS];

`ifdef SCAN_MASK_EN
    assign w_mask = bus.ch_mask;
`else
    assign w_mask = '1;
`endif

    for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
        assign w_chan[k] = bus.data_in[k*WIDTH +: WIDTH];
    end

    // Descending sweep: the last hit is the lowest enabled index overall and
    // the lowest enabled index strictly above the current channel.
    always_comb begin
        w_aboveFound = 1'b0;
        w_aboveCh    = '0;
        w_lowCh      = '0;
        w_anyEnabled = 1'b0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (w_mask[k]) begin
                w_anyEnabled = 1'b1;
                w_lowCh      = SEL_W'(k);
                if (k > int'(r_chOut)) begin
                    w_aboveFound = 1'b1;
                    w_aboveCh    = SEL_W'(k);
                end
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_nextCh    = r_chOut;
        w_nextValid = r_valid;
        w_nextWrap  = 1'b0;
        w_tgtCh     = r_chOut;
        w_tgtLegal  = 1'b0;
        if (!bus.hold) begin
            if (!bus.mode) begin
                w_nextState = MANUAL;
                w_nextCnt   = '0;
                w_tgtCh     = bus.sel;
                w_tgtLegal  = (int'(bus.sel) < CHANNELS);
                w_nextCh    = bus.sel;
                w_nextValid = w_tgtLegal;
            end else begin
                w_nextState = SCAN;
                if (!w_anyEnabled) begin
                    w_nextCnt   = '0;
                    w_nextValid = 1'b0;
                end else if (r_state == MANUAL) begin
                    w_nextCnt   = '0;
                    w_tgtCh     = w_lowCh;
                    w_tgtLegal  = 1'b1;
                    w_nextCh    = w_lowCh;
                    w_nextValid = 1'b1;
                end else if (r_cnt >= c_DWELL_LAST) begin
                    w_nextCnt   = '0;
                    w_tgtCh     = w_aboveFound ? w_aboveCh : w_lowCh;
                    w_tgtLegal  = 1'b1;
                    w_nextCh    = w_tgtCh;
                    w_nextValid = 1'b1;
                    w_nextWrap  = !w_aboveFound;
                end else begin
                    w_nextCnt   = r_cnt + 8'd1;
                    w_tgtLegal  = 1'b1;
                    w_nextValid = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_tgtData = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_tgtCh == SEL_W'(k)) begin
                w_tgtData = w_chan[k];
            end
        end
    end

    assign w_nextData = bus.hold ? r_data : (w_tgtLegal ? w_tgtData : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MANUAL;
            r_cnt   <= '0;
            r_chOut <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
            r_chOut <= w_nextCh;
            r_data  <= w_nextData;
            r_valid <= w_nextValid;
            r_wrap  <= w_nextWrap;
        end
    end

    assign bus.data_out  = r_data;
    assign bus.ch_out    = r_chOut;
    assign bus.valid     = r_valid;
    assign bus.scan_wrap = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_scan_mux_n.sv
// ============================================================================
// Module   : tb_scan_mux_n
// Brief    : Directed bench for scan_mux_n (8ch/DWELL=4 and 6ch/DWELL=1 units).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scan_mux_n;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int nChecks = 0;
    int nFail   = 0;

    scan_mux_n_if #(.CHANNELS(8), .WIDTH(1), .SEL_W(3)) bus8 ();
    scan_mux_n_if #(.CHANNELS(6), .WIDTH(1), .SEL_W(3)) bus6 ();

    scan_mux_n #(.CHANNELS(8), .WIDTH(1), .SEL_W(3), .DWELL(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8));
    scan_mux_n #(.CHANNELS(6), .WIDTH(1), .SEL_W(3), .DWELL(1)) dut6 (
        .clk(clk), .rst_n(rst_n), .bus(bus6));

    typedef struct {
        logic [2:0] sel;
        int         expData;
        int         expCh;
        int         expValid;
    } vec_t;

    vec_t manVec [8];
    vec_t oorVec [4];

    task automatic chk(input string nm, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk8(input string nm, input int d, input int c, input int v, input int w);
        chk({nm, ".data8"},  int'(bus8.data_out),  d);
        chk({nm, ".ch8"},    int'(bus8.ch_out),    c);
        chk({nm, ".valid8"}, int'(bus8.valid),     v);
        chk({nm, ".wrap8"},  int'(bus8.scan_wrap), w);
    endtask

    task automatic chk6(input string nm, input int d, input int c, input int v, input int w);
        chk({nm, ".data6"},  int'(bus6.data_out),  d);
        chk({nm, ".ch6"},    int'(bus6.ch_out),    c);
        chk({nm, ".valid6"}, int'(bus6.valid),     v);
        chk({nm, ".wrap6"},  int'(bus6.scan_wrap), w);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] d8;
        logic [5:0] d6;
        int ch;

        manVec = '{'{3'd0, 0, 0, 1}, '{3'd1, 1, 1, 1}, '{3'd2, 1, 2, 1}, '{3'd3, 0, 3, 1},
                   '{3'd4, 1, 4, 1}, '{3'd5, 0, 5, 1}, '{3'd6, 0, 6, 1}, '{3'd7, 1, 7, 1}};
        oorVec = '{'{3'd7, 0, 7, 0}, '{3'd5, 1, 5, 1}, '{3'd6, 0, 6, 0}, '{3'd1, 1, 1, 1}};

        d8 = 8'b1001_0110;
        d6 = 6'b10_0110;
        bus8.data_in = d8; bus8.sel = '0; bus8.mode = 1'b0; bus8.hold = 1'b0;
        bus6.data_in = d6; bus6.sel = '0; bus6.mode = 1'b0; bus6.hold = 1'b0;
`ifdef SCAN_MASK_EN
        bus8.ch_mask = '1;
        bus6.ch_mask = '1;
`endif
        repeat (2) step();
        chk8("reset", 0, 0, 0, 0);
        chk6("reset", 0, 0, 0, 0);
        rst_n = 1'b1;

        // Manual sweep, one-clock latency
        for (int i = 0; i < 8; i++) begin
            bus8.sel = manVec[i].sel;
            step();
            chk8($sformatf("manual[%0d]", i), manVec[i].expData, manVec[i].expCh, manVec[i].expValid, 0);
        end

        // Out-of-range selects on the 6-channel unit
        for (int i = 0; i < 4; i++) begin
            bus6.sel = oorVec[i].sel;
            step();
            chk6($sformatf("oor[%0d]", i), oorVec[i].expData, oorVec[i].expCh, oorVec[i].expValid, 0);
        end

        // Auto-scan, DWELL=4: wrap only on cycle 33
        bus8.mode = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            step();
            ch = ((n - 1) / 4) % 8;
            chk8($sformatf("scan[%0d]", n), int'(d8[ch]), ch, 1, (n == 33) ? 1 : 0);
        end

        // Hold at ch=3, counter=2
        bus8.mode = 1'b0;
        step();
        bus8.mode = 1'b1;
        repeat (15) step();
        chk8("preHold", int'(d8[3]), 3, 1, 0);
        bus8.hold = 1'b1;
        bus8.data_in = ~d8;
        for (int n = 0; n < 5; n++) begin
            step();
            chk8($sformatf("hold[%0d]", n), int'(d8[3]), 3, 1, 0);
        end
        d8 = ~d8;
        bus8.hold = 1'b0;
        step();
        chk8("release0", int'(d8[3]), 3, 1, 0);
        step();
        chk8("release1", int'(d8[4]), 4, 1, 0);

        // Asynchronous reset between edges while scanning
        #3;
        rst_n = 1'b0;
        #1;
        chk8("asyncRst", 0, 0, 0, 0);
        chk6("asyncRst", 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            step();
            ch = (n - 1) / 4;
            chk8($sformatf("postRst[%0d]", n), int'(d8[ch]), ch, 1, 0);
        end

        // DWELL=1 on a non-power-of-two channel count
        bus6.mode = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            step();
            ch = (n - 1) % 6;
            chk6($sformatf("dwell1[%0d]", n), int'(d6[ch]), ch, 1, (n == 7) ? 1 : 0);
        end
        bus6.mode = 1'b0;
        bus6.sel  = 3'd2;
        step();
        chk6("backToManual", int'(d6[2]), 2, 1, 0);

`ifdef SCAN_MASK_EN
        bus6.ch_mask = 6'b10_0101;
        bus6.mode = 1'b1;
        begin
            int seq [5] = '{0, 2, 5, 0, 2};
            for (int n = 0; n < 5; n++) begin
                step();
                chk6($sformatf("mask[%0d]", n), int'(d6[seq[n]]), seq[n], 1, (n == 3) ? 1 : 0);
            end
        end
        bus6.ch_mask = '0;
        step();
        chk6("maskZero", 0, 2, 0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

`default_nettype wire
